switch_bcd_counter: RTL and testbench

SWITCH_BCD_COUNTER -- requirements
Module: switch_bcd_counter

---
 rtl/seg_pkg.sv | 58 +++++
 rtl/switch_debounce.sv | 63 ++++++
 rtl/switch_bcd_counter.sv | 139 +++++++++++++
 tb/tb_switch_bcd_counter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared definitions for the two-digit BCD display slice.
//                Provides the digit width, the largest legal BCD digit, the
//                counter command encoding and BCD increment/decrement helpers.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_INC  = 2'd1,
        CMD_DEC  = 2'd2,
        CMD_CLR  = 2'd3
    } cmd_t;

    // Two-digit BCD increment, 99 wraps to 00. The >= compares keep an
    // out-of-range digit from ever propagating.
    function automatic logic [2*DIGIT_W-1:0] bcd_inc(
        input logic [DIGIT_W-1:0] t,
        input logic [DIGIT_W-1:0] o
    );
        logic [DIGIT_W-1:0] nt;
        logic [DIGIT_W-1:0] no;
        if (o >= BCD_MAX) begin
            no = '0;
            nt = (t >= BCD_MAX) ? '0 : t + 1'b1;
        end else begin
            no = o + 1'b1;
            nt = t;
        end
        return {nt, no};
    endfunction

    // Two-digit BCD decrement, 00 wraps to 99.
    function automatic logic [2*DIGIT_W-1:0] bcd_dec(
        input logic [DIGIT_W-1:0] t,
        input logic [DIGIT_W-1:0] o
    );
        logic [DIGIT_W-1:0] nt;
        logic [DIGIT_W-1:0] no;
        if (o == '0) begin
            no = BCD_MAX;
            nt = (t == '0) ? BCD_MAX : t - 1'b1;
        end else begin
            no = o - 1'b1;
            nt = t;
        end
        return {nt, no};
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debounce
//  Description : One board switch: 2-flop synchronizer, debounce counter and
//                registered rising-edge pulse.
//  Ports       : clk      - clock
//                arst     - asynchronous active-high reset
//                i_sw     - raw asynchronous switch level
//                o_level  - debounced level
//                o_rise   - one-cycle pulse, registered, on debounced 0->1
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic arst,
    input  logic i_sw,
    output logic o_level,
    output logic o_rise
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic               r_rise;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            // The level flips on the DEBOUNCE_CYCLES-th consecutive differing
            // cycle; any agreeing cycle restarts the count.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/switch_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module      : switch_bcd_counter
//  Description : Two-digit BCD up/down counter driven by debounced board
//                switches. Optional auto-count feature is built only when the
//                macro SWITCH_AUTO_COUNT_EN is defined.
//  Ports       : clk      - sole clock, rising edge
//                arst     - asynchronous active-high reset
//                switches - raw switches: [0] inc, [1] dec, [2] clear,
//                           [3] auto-count enable
//                tens     - BCD tens digit
//                ones     - BCD ones digit
//                update   - one-cycle pulse with each new tens/ones value
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_bcd_counter
    import seg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int AUTO_TICK_CYCLES = 100000000
) (
    input  logic               clk,
    input  logic               arst,
    input  logic [3:0]         switches,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               update
);

    logic [2:0]         w_level;
    logic [2:0]         w_rise;
    logic               w_tick;
    cmd_t               w_cmd;
    logic [DIGIT_W-1:0] r_tens;
    logic [DIGIT_W-1:0] r_ones;
    logic               r_update;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cmd_sw
            switch_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk     (clk),
                .arst    (arst),
                .i_sw    (switches[gi]),
                .o_level (w_level[gi]),
                .o_rise  (w_rise[gi])
            );
        end : g_cmd_sw
    endgenerate

    // Command switches only act on their rising edges.
    logic [2:0] w_unused_levels;
    assign w_unused_levels = w_level;

`ifdef SWITCH_AUTO_COUNT_EN
    localparam int c_pre_w = (AUTO_TICK_CYCLES > 1) ? $clog2(AUTO_TICK_CYCLES) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(AUTO_TICK_CYCLES - 1);

    logic               w_auto_level;
    logic               w_unused_auto_rise;
    logic [c_pre_w-1:0] r_presc;

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_auto (
        .clk     (clk),
        .arst    (arst),
        .i_sw    (switches[3]),
        .o_level (w_auto_level),
        .o_rise  (w_unused_auto_rise)
    );

    assign w_tick = w_auto_level && (r_presc == c_pre_last);

    // A clear restarts the tick interval so the next auto increment is a
    // full period after the clear.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_presc <= '0;
        end else if (!w_auto_level || w_rise[2]) begin
            r_presc <= '0;
        end else if (r_presc == c_pre_last) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end
`else
    logic w_unused_auto_sw;
    assign w_unused_auto_sw = switches[3];
    assign w_tick           = 1'b0;
`endif

    // Clear wins; an auto tick merges with a manual inc; inc against dec cancels.
    always_comb begin
        w_cmd = CMD_NONE;
        if (w_rise[2]) begin
            w_cmd = CMD_CLR;
        end else if ((w_rise[0] || w_tick) && !w_rise[1]) begin
            w_cmd = CMD_INC;
        end else if (w_rise[1] && !(w_rise[0] || w_tick)) begin
            w_cmd = CMD_DEC;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_tens   <= '0;
            r_ones   <= '0;
            r_update <= 1'b0;
        end else begin
            r_update <= 1'b0;
            unique case (w_cmd)
                CMD_CLR: begin
                    r_tens   <= '0;
                    r_ones   <= '0;
                    r_update <= 1'b1;
                end
                CMD_INC: begin
                    {r_tens, r_ones} <= bcd_inc(r_tens, r_ones);
                    r_update         <= 1'b1;
                end
                CMD_DEC: begin
                    {r_tens, r_ones} <= bcd_dec(r_tens, r_ones);
                    r_update         <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign tens   = r_tens;
    assign ones   = r_ones;
    assign update = r_update;

endmodule
`default_nettype wire

// File: tb/tb_switch_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_bcd_counter
//  Description : Self-checking bench for switch_bcd_counter with
//                DEBOUNCE_CYCLES=4, AUTO_TICK_CYCLES=20, 10 ns clock.
//                Expected auto-count results follow SWITCH_AUTO_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_bcd_counter;

    logic       clk;
    logic       arst;
    logic [3:0] switches;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       update;

    int errors = 0;
    int checks = 0;
    int upd_total = 0;
    int base;

    typedef struct {
        logic [2:0] mask;
        int         exp_tens;
        int         exp_ones;
        int         exp_upd;
    } vec_t;

    vec_t vecs[22];

`ifdef SWITCH_AUTO_COUNT_EN
    localparam bit AUTO_ON = 1'b1;
`else
    localparam bit AUTO_ON = 1'b0;
`endif

    switch_bcd_counter #(
        .DEBOUNCE_CYCLES  (4),
        .AUTO_TICK_CYCLES (20)
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .switches (switches),
        .tens     (tens),
        .ones     (ones),
        .update   (update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sole writer of the update-pulse tally, sampled 2 ns after each edge.
    always @(posedge clk) begin
        #2;
        if (update === 1'b1) upd_total++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [2:0] mask);
        @(negedge clk);
        switches[2:0] = mask;
        repeat (10) @(posedge clk);
        @(negedge clk);
        switches[2:0] = 3'b000;
        repeat (10) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Vector table: {switch mask, expected tens, ones, update pulses}
        vecs[0]  = '{3'b100, 0, 0, 1};
        vecs[1]  = '{3'b100, 0, 0, 1};
        vecs[2]  = '{3'b010, 9, 9, 1};
        vecs[3]  = '{3'b001, 0, 0, 1};
        vecs[4]  = '{3'b010, 9, 9, 1};
        vecs[5]  = '{3'b010, 9, 8, 1};
        vecs[6]  = '{3'b001, 9, 9, 1};
        vecs[7]  = '{3'b001, 0, 0, 1};
        for (int i = 8; i <= 16; i++) vecs[i] = '{3'b001, 0, i - 7, 1};
        vecs[17] = '{3'b001, 1, 0, 1};
        vecs[18] = '{3'b010, 0, 9, 1};
        vecs[19] = '{3'b011, 0, 9, 0};
        vecs[20] = '{3'b101, 0, 0, 1};
        vecs[21] = '{3'b111, 0, 0, 1};

        // Reset state
        arst     = 1'b1;
        switches = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        check("reset_tens", tens, 0);
        check("reset_ones", ones, 0);
        check("reset_update", update, 0);

        // First increment: exact latency from the first synchronizing edge
        arst     = 1'b0;
        switches = 4'b0001;
        base     = upd_total;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("lat_before_ones", ones, 0);
        check("lat_before_upd", upd_total - base, 0);
        @(posedge clk);
        @(negedge clk);
        check("lat_tens", tens, 0);
        check("lat_ones", ones, 1);
        check("lat_update_high", update, 1);
        @(negedge clk);
        check("lat_update_low", update, 0);
        switches = 4'b0000;
        repeat (10) @(posedge clk);
        @(negedge clk);

        // Table-driven commands
        foreach (vecs[i]) begin
            base = upd_total;
            press(vecs[i].mask);
            check($sformatf("vec%0d_tens", i), tens, vecs[i].exp_tens);
            check($sformatf("vec%0d_ones", i), ones, vecs[i].exp_ones);
            check($sformatf("vec%0d_upd", i), upd_total - base, vecs[i].exp_upd);
        end

        // Short glitch on inc must be filtered
        base = upd_total;
        @(negedge clk);
        switches[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 switches[0] = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("glitch_ones", ones, 0);
        check("glitch_upd", upd_total - base, 0);

        // Auto count from 00: first tick 20 cycles after the debounced level
        @(negedge clk);
        switches[3] = 1'b1;
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("auto_pre_tick", ones, 0);
        @(posedge clk);
        @(negedge clk);
        check("auto_first_tick", ones, AUTO_ON ? 1 : 0);
        repeat (74) @(posedge clk);
        @(negedge clk);
        check("auto_100_tens", tens, 0);
        check("auto_100_ones", ones, AUTO_ON ? 4 : 0);
        switches[3] = 1'b0;
        repeat (20) @(posedge clk);
        press(3'b100);
        check("auto_cleared", ones, 0);

        // Build 57 then reset in the middle of a debounce
        for (int k = 0; k < 57; k++) press(3'b001);
        check("v57_tens", tens, 5);
        check("v57_ones", ones, 7);
        @(negedge clk);
        switches[0] = 1'b1;
        repeat (4) @(posedge clk);
        #3 arst = 1'b1;
        #1;
        check("async_tens", tens, 0);
        check("async_ones", ones, 0);
        check("async_update", update, 0);
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        base = upd_total;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("post_rst_no_upd", upd_total - base, 0);
        check("post_rst_ones", ones, 0);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_fresh_ones", ones, 1);
        check("post_rst_fresh_upd", upd_total - base, 1);
        switches = 4'b0000;
        repeat (10) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
